reg_write_queue: RTL and testbench

REG_WRITE_QUEUE -- requirements
Module: reg_write_queue

---
 rtl/regs_pkg.sv | 20 ++
 rtl/reg_write_queue_if.sv | 26 ++
 rtl/single_register.sv | 27 ++
 rtl/reg_write_queue.sv | 119 +++++++++++
 tb/tb_reg_write_queue.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/regs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regs_pkg                                                  |
// | Purpose  : Shared defaults and helpers for the register bank and the |
// |            write queue that feeds it.                                |
// | Contents : c_default_bits, c_default_nregs, addr_width()             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package regs_pkg;

   localparam int c_default_bits  = 4;
   localparam int c_default_nregs = 4;

   // Index width for n registers; never narrower than one bit.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_write_queue_if                                        |
// | Purpose  : Valid/ready write-request channel into the write queue.   |
// | Ports    : in_valid, in_addr, in_data (producer -> queue)            |
// |            in_ready                  (queue -> producer)             |
// | Modports : master = request producer, slave = queue                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface reg_write_queue_if
   import regs_pkg::*;
#(
   parameter int bits  = c_default_bits,
   parameter int nregs = c_default_nregs
) ();

   logic                        in_valid;
   logic                        in_ready;
   logic [addr_width(nregs)-1:0] in_addr;
   logic [bits-1:0]             in_data;

   modport master (output in_valid, output in_addr, output in_data, input in_ready);
   modport slave  (input in_valid, input in_addr, input in_data, output in_ready);

endinterface
`default_nettype wire

// File: rtl/single_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : single_register                                           |
// | Purpose  : One storage register with write enable.                   |
// | Ports    : clk, rstn (sync, active-low), wenable, wdata -> q         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module single_register #(
   parameter int bits = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            wenable,
   input  logic [bits-1:0] wdata,
   output logic [bits-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         q <= '0;
      end else if (wenable) begin
         q <= wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_write_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_write_queue                                           |
// | Purpose  : FIFO of register writes draining into a register bank,    |
// |            one write per cycle unless stalled.                       |
// | Ports    : clk, rstn       clock / sync active-low reset             |
// |            req (slave)     in_valid/in_ready/in_addr/in_data         |
// |            wstall          blocks draining this cycle                |
// |            wenable, wdata  one-hot write strobe and shared data      |
// |            pending         registers targeted by queued entries      |
// |            count           number of queued entries                  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module reg_write_queue
   import regs_pkg::*;
#(
   parameter int bits  = c_default_bits,
   parameter int nregs = c_default_nregs,
   parameter int depth = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   reg_write_queue_if.slave         req,
   input  logic                     wstall,
   output logic [nregs-1:0]         wenable,
   output logic [bits-1:0]          wdata,
   output logic [nregs-1:0]         pending,
   output logic [$clog2(depth):0]   count
);

   localparam int c_aw = addr_width(nregs);
   localparam int c_pw = $clog2(depth);
   localparam int c_cw = c_pw + 1;
   localparam logic [c_cw-1:0]  c_full = c_cw'(depth);
   localparam logic [nregs-1:0] c_one  = {{(nregs-1){1'b0}}, 1'b1};

   logic [c_pw-1:0] r_wptr;
   logic [c_pw-1:0] r_rptr;
   logic [c_cw-1:0] r_count;
   logic [depth-1:0] r_valid;
   logic [c_aw-1:0] r_addr [depth];
   logic [bits-1:0] w_slot_q [depth];

   logic w_full;
   logic w_nonempty;
   logic w_push;
   logic w_pop;

   assign w_full     = (r_count == c_full);
   assign w_nonempty = (r_count != '0);
   // A full queue refuses a push even when a pop frees a slot this cycle.
   assign w_push     = req.in_valid && !w_full;
   assign w_pop      = w_nonempty && !wstall;
   // Count reads as zero while rstn is low, so ready must read as one.
   assign req.in_ready = !rstn || !w_full;

   // Slot data lives in register instances loaded by the write pointer decode.
   for (genvar i = 0; i < depth; i++) begin : g_slot
      single_register #(.bits(bits)) u_data (
         .clk     (clk),
         .rstn    (rstn),
         .wenable (w_push && (r_wptr == c_pw'(i))),
         .wdata   (req.in_data),
         .q       (w_slot_q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_valid <= '0;
         for (int i = 0; i < depth; i++) begin
            r_addr[i] <= '0;
         end
      end else begin
         // Pointers wrap on their own because depth is a power of two.
         if (w_pop) begin
            r_valid[r_rptr] <= 1'b0;
            r_rptr          <= r_rptr + c_pw'(1);
         end
         if (w_push) begin
            r_valid[r_wptr] <= 1'b1;
            r_addr[r_wptr]  <= req.in_addr;
            r_wptr          <= r_wptr + c_pw'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cw'(1);
            2'b01:   r_count <= r_count - c_cw'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Outputs come only from stored state and wstall; all forced to zero in reset.
   always_comb begin
      wenable = '0;
      wdata   = '0;
      pending = '0;
      count   = '0;
      if (rstn) begin
         for (int i = 0; i < depth; i++) begin
            if (r_valid[i]) begin
               pending = pending | (c_one << r_addr[i]);
            end
         end
         count = r_count;
         if (w_nonempty) begin
            wdata = w_slot_q[r_rptr];
         end
         if (w_pop) begin
            wenable = c_one << r_addr[r_rptr];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_write_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_reg_write_queue                                        |
// | Purpose  : Self-checking bench for reg_write_queue (bits=4, nregs=4, |
// |            depth=4): directed scenarios followed by random traffic,  |
// |            scored against a plain FIFO reference model.              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_reg_write_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [1:0] addr;
      logic [3:0] data;
   } ent_t;

   logic       clk;
   logic       rstn;
   logic       wstall;
   logic [3:0] wenable;
   logic [3:0] wdata;
   logic [3:0] pending;
   logic [2:0] count;

   int tests;
   int fails;

   ent_t sb[$];

   reg_write_queue_if #(.bits(4), .nregs(4)) bus ();

   reg_write_queue #(.bits(4), .nregs(4), .depth(DEPTH)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .req     (bus),
      .wstall  (wstall),
      .wenable (wenable),
      .wdata   (wdata),
      .pending (pending),
      .count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Inputs change just after the rising edge and hold until the next one.
   task automatic step(input bit v, input int a, input int d, input bit s);
      logic [31:0] av;
      logic [31:0] dv;
      av = a;
      dv = d;
      bus.in_valid = v;
      bus.in_addr  = av[1:0];
      bus.in_data  = dv[3:0];
      wstall       = s;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares DUT outputs at the falling edge against the model,
   // then advances the model by what the coming rising edge will do.
   always @(negedge clk) begin
      int         e_cnt;
      logic [3:0] e_we;
      logic [3:0] e_wd;
      logic [3:0] e_pend;
      logic       e_rdy;
      bit         acc;
      ent_t       e;
      if (!rstn) begin
         e_cnt = 0; e_we = 4'b0; e_wd = 4'b0; e_pend = 4'b0; e_rdy = 1'b1;
      end else begin
         e_cnt  = sb.size();
         e_rdy  = (e_cnt != DEPTH);
         e_pend = 4'b0;
         foreach (sb[i]) e_pend = e_pend | (4'b0001 << sb[i].addr);
         e_wd   = (e_cnt != 0) ? sb[0].data : 4'b0;
         e_we   = (e_cnt != 0 && !wstall) ? (4'b0001 << sb[0].addr) : 4'b0;
      end
      check("count",    {29'b0, count},        e_cnt);
      check("in_ready", {31'b0, bus.in_ready}, {31'b0, e_rdy});
      check("pending",  {28'b0, pending},      {28'b0, e_pend});
      check("wenable",  {28'b0, wenable},      {28'b0, e_we});
      check("wdata",    {28'b0, wdata},        {28'b0, e_wd});
      if (!rstn) begin
         sb.delete();
      end else begin
         acc = bus.in_valid && (sb.size() < DEPTH);
         if (e_we != 4'b0) void'(sb.pop_front());
         if (acc) begin
            e.addr = bus.in_addr;
            e.data = bus.in_data;
            sb.push_back(e);
         end
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      rstn = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_addr  = 2'd0;
      bus.in_data  = 4'd0;
      wstall       = 1'b0;
      #1;
      // Reset held for two edges with a request offered.
      step(1, 1, 5, 0);
      step(1, 1, 5, 0);
      rstn = 1'b1;
      // Single write into an empty queue.
      step(1, 2, 4'b1010, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      // Fill with drain stalled; the fifth offer is refused.
      step(1, 0, 4'b1111, 1);
      step(1, 1, 4'b0001, 1);
      step(1, 2, 4'b0010, 1);
      step(1, 3, 4'b0011, 1);
      step(1, 0, 4'b0100, 1);
      step(0, 0, 0, 1);
      // Release the stall and drain in order.
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
      // Build count=2, then push every cycle while draining.
      step(1, 3, 4'h6, 1);
      step(1, 1, 4'h7, 1);
      for (int i = 0; i < 8; i++) step(1, i % 4, 8 + i, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
      // Reset with three entries queued, then watch for stale writes.
      step(1, 0, 4'h9, 1);
      step(1, 1, 4'hA, 1);
      step(1, 2, 4'hB, 1);
      rstn = 1'b0;
      step(1, 3, 4'hC, 0);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
      // Random traffic with bursty stalls and rare resets.
      for (int n = 0; n < 2000; n++) begin
         rstn = ($urandom_range(0, 249) != 0);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 15),
              ((n / 64) % 2 == 1) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2));
      end
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
